// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage.
// Takes the ALU result as the effective address and performs one load or
// store over a request/acknowledge bus. Illegal or misaligned accesses are
// rejected at accept time and never reach the bus. Load results are
// sign- or zero-extended for writeback and held until the next load.
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic        is_store,
    input  logic [2:0]  data_format,
    output logic        ready,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal_format,
    output logic [31:0] bus_address,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;

    // Access attributes captured at accept; the live inputs may change
    // while the access is in flight.
    logic [2:0]  format_q;
    logic [1:0]  offset_q;
    logic        store_q;

    // Decode of the request currently presented on the inputs.
    logic        illegal_in;
    logic        misaligned_in;
    logic [3:0]  byte_enable_in;
    logic [31:0] write_data_in;

    // Extended load value built from the returning bus word.
    logic [7:0]  read_byte;
    logic [15:0] read_half;
    logic [31:0] load_extended;

    // Classify the presented request and precompute its lane strobes and
    // replicated write data. Illegal formats take precedence over
    // misalignment so only one flag is ever reported.
    always_comb begin
        illegal_in     = 1'b0;
        misaligned_in  = 1'b0;
        byte_enable_in = 4'b0000;
        write_data_in  = store_data;

        case (data_format)
            3'b011, 3'b110, 3'b111: illegal_in = 1'b1;
            3'b100, 3'b101:         illegal_in = is_store;
            default:                illegal_in = 1'b0;
        endcase

        if ((data_format[1:0] == 2'b01) && address[0]) begin
            misaligned_in = 1'b1;
        end
        if ((data_format == 3'b010) && (address[1:0] != 2'b00)) begin
            misaligned_in = 1'b1;
        end

        case (data_format[1:0])
            2'b00: begin
                byte_enable_in = 4'b0001 << address[1:0];
                write_data_in  = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_enable_in = address[1] ? 4'b1100 : 4'b0011;
                write_data_in  = {2{store_data[15:0]}};
            end
            default: begin
                byte_enable_in = 4'b1111;
                write_data_in  = store_data;
            end
        endcase
    end

    // Select the addressed byte/halfword from the bus word and extend it
    // according to the captured format.
    always_comb begin
        read_byte     = 8'h00;
        read_half     = 16'h0000;
        load_extended = bus_read_data;

        case (offset_q)
            2'd0:    read_byte = bus_read_data[7:0];
            2'd1:    read_byte = bus_read_data[15:8];
            2'd2:    read_byte = bus_read_data[23:16];
            default: read_byte = bus_read_data[31:24];
        endcase

        read_half = offset_q[1] ? bus_read_data[31:16] : bus_read_data[15:0];

        case (format_q)
            3'b000:  load_extended = {{24{read_byte[7]}}, read_byte};
            3'b100:  load_extended = {24'h000000, read_byte};
            3'b001:  load_extended = {{16{read_half[15]}}, read_half};
            3'b101:  load_extended = {16'h0000, read_half};
            default: load_extended = bus_read_data;
        endcase
    end

    // Control FSM with all outputs registered: accept and check in IDLE,
    // hold the bus request in BUS until acknowledged, pulse done in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            format_q         <= 3'b000;
            offset_q         <= 2'b00;
            store_q          <= 1'b0;
            ready            <= 1'b1;
            done             <= 1'b0;
            load_data        <= 32'h0000_0000;
            misaligned       <= 1'b0;
            illegal_format   <= 1'b0;
            bus_address      <= 32'h0000_0000;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_byte_enable  <= 4'b0000;
            bus_write_data   <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ready          <= 1'b0;
                        format_q       <= data_format;
                        offset_q       <= address[1:0];
                        store_q        <= is_store;
                        illegal_format <= illegal_in;
                        misaligned     <= misaligned_in && !illegal_in;
                        if (illegal_in || misaligned_in) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bus_address      <= {address[31:2], 2'b00};
                            bus_read_enable  <= !is_store;
                            bus_write_enable <= is_store;
                            bus_byte_enable  <= byte_enable_in;
                            bus_write_data   <= write_data_in;
                            state            <= BUS;
                        end
                    end
                end

                BUS: begin
                    if (bus_ack) begin
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        if (!store_q) begin
                            load_data <= load_extended;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
